serial_mag_comparator: RTL and testbench



---
 rtl/cmp_pkg.sv | 20 ++
 rtl/cmp_digit.sv | 16 +
 rtl/serial_mag_comparator.sv | 171 +++++++++++++++++
 tb/tb_serial_mag_comparator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and helpers for the serial magnitude comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cmp_state_t;

    typedef enum logic [1:0] {
        GT,
        EQ,
        LT
    } cmp_res_t;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// rtl/cmp_digit.sv - combinational DIGIT-bit unsigned compare of one digit pair
module cmp_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             gt_o,
    output logic             eq_o,
    output logic             lt_o
);

    assign gt_o = (a_i > b_i);
    assign eq_o = (a_i == b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/serial_mag_comparator.sv
// rtl/serial_mag_comparator.sv - MSB-first digit-serial magnitude comparator
// CMP_EARLY_EXIT_EN: finish on the first differing digit instead of after NDIG cycles.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGIT  = 1,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]    CNT_LAST  = CW'(NDIG - 1);
    // Flipping the sign bit maps two's complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_FLIP = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_err
        $error("serial_mag_comparator: DIGIT must divide WIDTH exactly");
    end

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
`ifndef CMP_EARLY_EXIT_EN
    cmp_res_t         sticky_q, sticky_d;
    cmp_res_t         hit_res;
`endif

    logic     dig_gt, dig_eq, dig_lt;
    cmp_res_t cur_res;
    cmp_res_t res;
    logic     set_res;

    cmp_digit #(.DIGIT(DIGIT)) u_digit (
        .a_i  (a_q[WIDTH-1 -: DIGIT]),
        .b_i  (b_q[WIDTH-1 -: DIGIT]),
        .gt_o (dig_gt),
        .eq_o (dig_eq),
        .lt_o (dig_lt)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        res     = EQ;
        set_res = 1'b0;
        cur_res = dig_gt ? GT : (dig_lt ? LT : EQ);
`ifndef CMP_EARLY_EXIT_EN
        sticky_d = sticky_q;
        hit_res  = (sticky_q == EQ) ? cur_res : sticky_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a ^ SIGN_FLIP;
                    b_d     = b ^ SIGN_FLIP;
                    cnt_d   = CNT_LAST;
                    state_d = RUN;
`ifndef CMP_EARLY_EXIT_EN
                    sticky_d = EQ;
`endif
                end
            end
            RUN: begin
`ifdef CMP_EARLY_EXIT_EN
                if (!dig_eq) begin
                    res     = cur_res;
                    set_res = 1'b1;
                end else if (cnt_q == '0) begin
                    res     = EQ;
                    set_res = 1'b1;
                end else begin
                    a_d   = a_q << DIGIT;
                    b_d   = b_q << DIGIT;
                    cnt_d = cnt_q - CW'(1);
                end
`else
                // The first mismatch is latched; later digits cannot overturn it.
                if (cnt_q == '0) begin
                    res     = hit_res;
                    set_res = 1'b1;
                end else begin
                    sticky_d = hit_res;
                    a_d      = a_q << DIGIT;
                    b_d      = b_q << DIGIT;
                    cnt_d    = cnt_q - CW'(1);
                end
`endif
                if (set_res) begin
                    state_d = DONE;
                    gt_d    = (res == GT);
                    eq_d    = (res == EQ);
                    lt_d    = (res == LT);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                gt_d    = 1'b0;
                eq_d    = 1'b0;
                lt_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

`ifndef CMP_EARLY_EXIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= EQ;
        end else begin
            sticky_q <= sticky_d;
        end
    end
`endif

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb/tb_serial_mag_comparator.sv - scoreboard bench for serial_mag_comparator
`timescale 1ns/1ps
module tb_serial_mag_comparator;

    localparam int NDUT = 3;
`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid  [NDUT];
    logic       in_ready  [NDUT];
    logic       out_valid [NDUT];
    logic       out_ready [NDUT];
    logic       gt        [NDUT];
    logic       eq        [NDUT];
    logic       lt        [NDUT];
    logic [7:0] a         [NDUT];
    logic [7:0] b         [NDUT];

    always #5 clk = ~clk;

    serial_mag_comparator #(.WIDTH(8), .DIGIT(1), .SIGNED(0)) u_d1u (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .gt(gt[0]), .eq(eq[0]), .lt(lt[0])
    );
    serial_mag_comparator #(.WIDTH(8), .DIGIT(1), .SIGNED(1)) u_d1s (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .gt(gt[1]), .eq(eq[1]), .lt(lt[1])
    );
    serial_mag_comparator #(.WIDTH(8), .DIGIT(4), .SIGNED(0)) u_d4u (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2]), .b(b[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .gt(gt[2]), .eq(eq[2]), .lt(lt[2])
    );

    typedef struct {
        int         dut;
        logic [2:0] res;
        int         lat;
        int         acc;
    } sb_t;

    sb_t sbq[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    logic prev_ov [NDUT];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        for (int d = 0; d < NDUT; d++) begin
            if (!rst && out_valid[d] === 1'b1 && prev_ov[d] !== 1'b1) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result dut%0d: got gt/eq/lt %b%b%b expected no result",
                             d, gt[d], eq[d], lt[d]);
                end else begin
                    e = sbq.pop_front();
                    check("result_dut", d, e.dut);
                    check($sformatf("result_dut%0d", d), {29'd0, gt[d], eq[d], lt[d]}, {29'd0, e.res});
                    check($sformatf("latency_dut%0d", d), cyc - e.acc, e.lat);
                end
            end
            prev_ov[d] = out_valid[d];
        end
    end

    task automatic wait_ready(input int d);
        int n = 0;
        while (in_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready[d] !== 1'b1) check($sformatf("in_ready_timeout_dut%0d", d), 0, 1);
    endtask

    task automatic issue(input int d, input logic [7:0] av, input logic [7:0] bv,
                         input logic [2:0] res, input int lat);
        sb_t e;
        @(negedge clk);
        wait_ready(d);
        a[d] = av;
        b[d] = bv;
        in_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        e.dut = d;
        e.res = res;
        e.lat = lat;
        e.acc = cyc;
        sbq.push_back(e);
    endtask

    task automatic run(input int d, input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] res, input int lat);
        issue(d, av, bv, res, lat);
        @(negedge clk);
        wait_ready(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            a[d]         = '0;
            b[d]         = '0;
            prev_ov[d]   = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset_in_ready_dut%0d", d), in_ready[d], 0);
            check($sformatf("reset_out_dut%0d", d), {out_valid[d], gt[d], eq[d], lt[d]}, 0);
        end
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", in_ready[0], 1);

        run(0, 8'hA5, 8'hA5, R_EQ, 8);
        run(0, 8'h80, 8'h7F, R_GT, EARLY ? 1 : 8);
        run(0, 8'h80, 8'h01, R_GT, EARLY ? 1 : 8);
        run(0, 8'h3C, 8'h3D, R_LT, 8);
        run(1, 8'h80, 8'h01, R_LT, EARLY ? 1 : 8);
        run(1, 8'h7F, 8'hFF, R_GT, EARLY ? 1 : 8);
        run(1, 8'hFE, 8'hFF, R_LT, 8);
        run(1, 8'h05, 8'h05, R_EQ, 8);
        run(2, 8'h3C, 8'h3D, R_LT, 2);
        run(2, 8'h4C, 8'h3D, R_GT, EARLY ? 1 : 2);
        run(2, 8'h00, 8'h00, R_EQ, 2);
        run(2, 8'hFF, 8'h0F, R_GT, EARLY ? 1 : 2);

        // Backpressure: result held in DONE, stray in_valid ignored.
        out_ready[0] = 1'b0;
        issue(0, 8'h80, 8'h7F, R_GT, EARLY ? 1 : 8);
        n = 0;
        while (out_valid[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_timeout", out_valid[0], 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", out_valid[0], 1);
            check("bp_hold_result", {gt[0], eq[0], lt[0]}, R_GT);
            check("bp_hold_in_ready", in_ready[0], 0);
            a[0] = 8'h00;
            b[0] = 8'hFF;
            in_valid[0] = (i == 1);
            @(negedge clk);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready[0], 1);
        check("bp_release_out", {out_valid[0], gt[0], eq[0], lt[0]}, 0);

        // Asynchronous reset in the third RUN cycle of an 8-cycle compare.
        @(negedge clk);
        wait_ready(0);
        a[0] = 8'hA5;
        b[0] = 8'hA5;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_out", {out_valid[0], gt[0], eq[0], lt[0]}, 0);
        check("rst_mid_in_ready", in_ready[0], 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", in_ready[0], 1);
        run(0, 8'h01, 8'h02, R_LT, EARLY ? 7 : 8);

        repeat (12) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
